// File: rtl/gfx_triangle_setup.sv
// gfx_triangle_setup: clip-clamped bounding box, doubled signed area and cull flag for one triangle.
// One multiplier is shared across two cycles for the edge cross product.
module gfx_triangle_setup #(
  parameter int point_width = 16,
  parameter int subpixel_width = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [point_width+subpixel_width-1:0] p0_x_i,
  input  logic [point_width+subpixel_width-1:0] p0_y_i,
  input  logic [point_width+subpixel_width-1:0] p1_x_i,
  input  logic [point_width+subpixel_width-1:0] p1_y_i,
  input  logic [point_width+subpixel_width-1:0] p2_x_i,
  input  logic [point_width+subpixel_width-1:0] p2_y_i,
  input  logic signed [point_width-1:0] clip_x0_i,
  input  logic signed [point_width-1:0] clip_y0_i,
  input  logic signed [point_width-1:0] clip_x1_i,
  input  logic signed [point_width-1:0] clip_y1_i,
  input  logic cull_enable_i,
  input  logic start_i,
  output logic busy_o,
  output logic ack_o,
  output logic signed [point_width-1:0] bbox_min_x_o,
  output logic signed [point_width-1:0] bbox_min_y_o,
  output logic signed [point_width-1:0] bbox_max_x_o,
  output logic signed [point_width-1:0] bbox_max_y_o,
  output logic signed [2*point_width+2:0] area_o,
  output logic culled_o
);
  localparam int pw = point_width;
  localparam int sw = subpixel_width;
  localparam int dw = pw + 1;
  localparam int mw = 2 * pw + 2;
  localparam int aw = 2 * pw + 3;
  typedef enum logic [2:0] {idle, bbox, mul0, mul1, done} state_t;
  state_t state, state_n;
  logic latch_en, bbox_en, done_en;
  logic signed [pw-1:0] x0, y0, x1, y1, x2, y2, cx0, cy0, cx1, cy1;
  logic signed [pw-1:0] min_x, min_y, max_x, max_y;
  logic cull_en;
  logic signed [dw-1:0] dx1, dy1, dx2, dy2, mul_a, mul_b;
  logic signed [mw-1:0] prod0, prod1, prod;
  logic signed [aw-1:0] area_c;
  logic culled_c;
  logic unused_frac;
  function automatic logic signed [pw-1:0] smin(input logic signed [pw-1:0] a, input logic signed [pw-1:0] b);
    return (a < b) ? a : b;
  endfunction
  function automatic logic signed [pw-1:0] smax(input logic signed [pw-1:0] a, input logic signed [pw-1:0] b);
    return (a > b) ? a : b;
  endfunction
  assign unused_frac = ^{p0_x_i[sw-1:0], p0_y_i[sw-1:0], p1_x_i[sw-1:0],
                         p1_y_i[sw-1:0], p2_x_i[sw-1:0], p2_y_i[sw-1:0]};
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= idle;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      idle: state_n = start_i ? bbox : idle;
      bbox: state_n = mul0;
      mul0: state_n = mul1;
      mul1: state_n = done;
      default: state_n = idle;
    endcase
  end
  always_comb begin
    latch_en = (state == idle) && start_i;
    bbox_en = state == bbox;
    done_en = state == done;
  end
  // MUL0 forms dx1*dy2, MUL1 forms dx2*dy1 on the same multiplier
  assign mul_a = (state == mul0) ? dx1 : dx2;
  assign mul_b = (state == mul0) ? dy2 : dy1;
  assign prod = mw'(mul_a) * mw'(mul_b);
  assign area_c = aw'(prod0) - aw'(prod1);
  assign culled_c = (min_x > max_x) || (min_y > max_y) || (cull_en && (area_c[aw-1] || area_c == '0));
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      {x0, y0, x1, y1, x2, y2, cx0, cy0, cx1, cy1} <= '0;
      {min_x, min_y, max_x, max_y} <= '0;
      {dx1, dy1, dx2, dy2, prod0, prod1} <= '0;
      cull_en <= 1'b0;
      busy_o <= 1'b0;
      ack_o <= 1'b0;
      culled_o <= 1'b0;
      area_o <= '0;
      {bbox_min_x_o, bbox_min_y_o, bbox_max_x_o, bbox_max_y_o} <= '0;
    end else begin
      ack_o <= done_en;
      if (latch_en) begin
        x0 <= p0_x_i[sw +: pw];
        y0 <= p0_y_i[sw +: pw];
        x1 <= p1_x_i[sw +: pw];
        y1 <= p1_y_i[sw +: pw];
        x2 <= p2_x_i[sw +: pw];
        y2 <= p2_y_i[sw +: pw];
        cx0 <= clip_x0_i;
        cy0 <= clip_y0_i;
        cx1 <= clip_x1_i;
        cy1 <= clip_y1_i;
        cull_en <= cull_enable_i;
        busy_o <= 1'b1;
      end
      if (bbox_en) begin
        min_x <= smax(smin(smin(x0, x1), x2), cx0);
        min_y <= smax(smin(smin(y0, y1), y2), cy0);
        max_x <= smin(smax(smax(x0, x1), x2), cx1);
        max_y <= smin(smax(smax(y0, y1), y2), cy1);
        dx1 <= dw'(x1) - dw'(x0);
        dy1 <= dw'(y1) - dw'(y0);
        dx2 <= dw'(x2) - dw'(x0);
        dy2 <= dw'(y2) - dw'(y0);
      end
      if (state == mul0) prod0 <= prod;
      if (state == mul1) prod1 <= prod;
      if (done_en) begin
        area_o <= area_c;
        bbox_min_x_o <= min_x;
        bbox_min_y_o <= min_y;
        bbox_max_x_o <= max_x;
        bbox_max_y_o <= max_y;
        culled_o <= culled_c;
        busy_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gfx_triangle_setup.sv
// tb_gfx_triangle_setup: directed scoreboard bench for gfx_triangle_setup.
module tb_gfx_triangle_setup;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] p0x, p0y, p1x, p1y, p2x, p2y;
  logic signed [15:0] cx0, cy0, cx1, cy1;
  logic cull, start;
  logic busy, ack, culled;
  logic signed [15:0] bminx, bminy, bmaxx, bmaxy;
  logic signed [34:0] area;
  int checks = 0;
  int passed = 0;
  typedef struct {
    longint area;
    int minx, miny, maxx, maxy;
    bit culled;
  } exp_t;
  exp_t q[$];

  gfx_triangle_setup #(.point_width(16), .subpixel_width(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_x_i(p0x), .p0_y_i(p0y), .p1_x_i(p1x), .p1_y_i(p1y), .p2_x_i(p2x), .p2_y_i(p2y),
    .clip_x0_i(cx0), .clip_y0_i(cy0), .clip_x1_i(cx1), .clip_y1_i(cy1),
    .cull_enable_i(cull), .start_i(start),
    .busy_o(busy), .ack_o(ack),
    .bbox_min_x_o(bminx), .bbox_min_y_o(bminy), .bbox_max_x_o(bmaxx), .bbox_max_y_o(bmaxy),
    .area_o(area), .culled_o(culled)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic int fx(input int v);
    return v * 65536;
  endfunction

  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction

  function automatic exp_t model(input int ax, ay, bx, by, qx, qy, c0, c1, c2, c3, input bit cu);
    exp_t e;
    int x0, y0, x1, y1, x2, y2;
    x0 = ax >>> 16; y0 = ay >>> 16;
    x1 = bx >>> 16; y1 = by >>> 16;
    x2 = qx >>> 16; y2 = qy >>> 16;
    e.minx = imax(imin(imin(x0, x1), x2), c0);
    e.miny = imax(imin(imin(y0, y1), y2), c1);
    e.maxx = imin(imax(imax(x0, x1), x2), c2);
    e.maxy = imin(imax(imax(y0, y1), y2), c3);
    e.area = longint'(x1 - x0) * longint'(y2 - y0) - longint'(x2 - x0) * longint'(y1 - y0);
    e.culled = (e.minx > e.maxx) || (e.miny > e.maxy) || (cu && e.area <= 0);
    return e;
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one request at the current negedge; scramble inputs after the start cycle.
  task automatic issue(input int ax, ay, bx, by, qx, qy, c0, c1, c2, c3, input bit cu);
    p0x = ax; p0y = ay; p1x = bx; p1y = by; p2x = qx; p2y = qy;
    cx0 = 16'(c0); cy0 = 16'(c1); cx1 = 16'(c2); cy1 = 16'(c3);
    cull = cu;
    start = 1'b1;
    q.push_back(model(ax, ay, bx, by, qx, qy, c0, c1, c2, c3, cu));
    @(negedge clk);
    start = 1'b0;
    p0x = $urandom; p0y = $urandom; p1x = $urandom; p1y = $urandom; p2x = $urandom; p2y = $urandom;
    cx0 = 16'($urandom); cy0 = 16'($urandom); cx1 = 16'($urandom); cy1 = 16'($urandom);
    cull = ~cu;
  endtask

  task automatic wait_ack(input bit poke);
    int lat = 0;
    int busy_n = 0;
    exp_t e;
    while (!ack && lat < 12) begin
      if (busy) busy_n++;
      if (poke && (lat == 0 || lat == 2)) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk("latency", lat, 4);
    chk("busy_cycles", busy_n, 4);
    chk("busy_at_ack", longint'(busy), 0);
    if (q.size() != 0) begin
      e = q.pop_front();
      if (ack) begin
        chk("area", longint'(area), e.area);
        chk("min_x", longint'(bminx), e.minx);
        chk("min_y", longint'(bminy), e.miny);
        chk("max_x", longint'(bmaxx), e.maxx);
        chk("max_y", longint'(bmaxy), e.maxy);
        chk("culled", longint'(culled), longint'(e.culled));
      end
    end
  endtask

  task automatic run(input int ax, ay, bx, by, qx, qy, c0, c1, c2, c3, input bit cu);
    issue(ax, ay, bx, by, qx, qy, c0, c1, c2, c3, cu);
    wait_ack(1'b0);
    @(negedge clk);
    chk("ack_one_cycle", longint'(ack), 0);
  endtask

  task automatic count_acks(input int n, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
  endtask

  initial begin
    int acks;
    start = 1'b0; cull = 1'b0;
    {p0x, p0y, p1x, p1y, p2x, p2y} = '0;
    {cx0, cy0, cx1, cy1} = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ack", longint'(ack), 0);
    chk("rst_area", longint'(area), 0);
    chk("rst_min_x", longint'(bminx), 0);
    chk("rst_max_y", longint'(bmaxy), 0);
    chk("rst_culled", longint'(culled), 0);
    rst = 1'b0;
    @(negedge clk);
    // basic counter-clockwise triangle
    run(fx(10), fx(10), fx(20), fx(10), fx(10), fx(30), 0, 0, 639, 479, 1'b1);
    chk("t2_area_const", longint'(area), 200);
    // reset while in MUL0
    issue(fx(10), fx(10), fx(20), fx(10), fx(10), fx(30), 0, 0, 639, 479, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    void'(q.pop_back());
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_ack", longint'(ack), 0);
    chk("mid_rst_area", longint'(area), 0);
    chk("mid_rst_max_x", longint'(bmaxx), 0);
    chk("mid_rst_culled", longint'(culled), 0);
    @(negedge clk);
    rst = 1'b0;
    count_acks(8, acks);
    chk("mid_rst_no_ack", acks, 0);
    // winding, degenerate and cull enable
    run(fx(10), fx(10), fx(10), fx(30), fx(20), fx(10), 0, 0, 639, 479, 1'b1);
    chk("t3_area_const", longint'(area), -200);
    run(fx(10), fx(10), fx(10), fx(30), fx(20), fx(10), 0, 0, 639, 479, 1'b0);
    run(fx(0), fx(0), fx(5), fx(5), fx(10), fx(10), 0, 0, 639, 479, 1'b1);
    run(fx(0), fx(0), fx(5), fx(5), fx(10), fx(10), 0, 0, 639, 479, 1'b0);
    // clamping and empty box
    run(fx(-5), fx(-5), fx(700), fx(3), fx(3), fx(500), 0, 0, 639, 479, 1'b1);
    run(fx(700), fx(10), fx(720), fx(10), fx(700), fx(50), 0, 0, 639, 479, 1'b0);
    // floor of -0.5 is -1
    run(32'hFFFF8000, 0, fx(4), 0, 0, fx(4), -100, -100, 639, 479, 1'b1);
    chk("floor_min_x", longint'(bminx), -1);
    chk("floor_area", longint'(area), 20);
    // start while busy is ignored
    issue(fx(1), fx(2), fx(9), fx(3), fx(4), fx(8), 0, 0, 639, 479, 1'b1);
    wait_ack(1'b1);
    count_acks(8, acks);
    chk("ignored_start_acks", acks, 0);
    // start in the ack cycle is accepted
    issue(fx(3), fx(3), fx(13), fx(3), fx(3), fx(9), 0, 0, 639, 479, 1'b1);
    wait_ack(1'b0);
    issue(fx(-20), fx(5), fx(30), fx(40), fx(100), fx(-7), -10, -10, 50, 50, 1'b0);
    wait_ack(1'b0);
    @(negedge clk);
    chk("b2b_ack_one_cycle", longint'(ack), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
